// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the multi-cycle datapath and alu_multicycle.
// The master drives the operation request and the slave returns registered results.
interface alu_multicycle_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [2:0]       ALUControl;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] Result;
   logic [WIDTH-1:0] Result_Hi;
   logic             Zero_Flag;
   logic             Overflow;
   logic             Busy;
   logic             Done;

   modport master (
      output Start, ALUControl, A, B,
      input  Result, Result_Hi, Zero_Flag, Overflow, Busy, Done
   );

   modport slave (
      input  Start, ALUControl, A, B,
      output Result, Result_Hi, Zero_Flag, Overflow, Busy, Done
   );
endinterface

// File: rtl/alu_multicycle.sv
// Clocked ALU: single-cycle logic/arithmetic ops, plus iterative unsigned multiply
// (shift-add) and unsigned divide (restoring), each taking WIDTH clocks.
module alu_multicycle #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           reset,
   alu_multicycle_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_ADD  = 3'd2,
      OP_MULU = 3'd3,
      OP_DIVU = 3'd4,
      OP_XOR  = 3'd5,
      OP_SUB  = 3'd6,
      OP_SLT  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_e;

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] acc_hi_q;   // MUL: partial product high; DIV: partial remainder
   logic [WIDTH-1:0] acc_lo_q;   // MUL: multiplier/product low; DIV: dividend/quotient
   logic [WIDTH-1:0] opnd_q;     // MUL: multiplicand; DIV: divisor
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result_hi_q;
   logic             zero_q;
   logic             ovf_q;
   logic             busy_q;
   logic             done_q;

   op_e              op;
   logic [WIDTH-1:0] add_sum;
   logic [WIDTH-1:0] sub_diff;
   logic [WIDTH-1:0] simple_res;
   logic             simple_ovf;

   assign op       = op_e'(bus.ALUControl);
   assign add_sum  = bus.A + bus.B;
   assign sub_diff = bus.A - bus.B;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      simple_res = '0;
      simple_ovf = 1'b0;
      case (op)
         OP_AND: simple_res = bus.A & bus.B;
         OP_OR:  simple_res = bus.A | bus.B;
         OP_XOR: simple_res = bus.A ^ bus.B;
         OP_ADD: begin
            simple_res = add_sum;
            simple_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                         (add_sum[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SUB: begin
            simple_res = sub_diff;
            simple_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                         (sub_diff[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
         default: simple_res = '0;
      endcase
   end

   // One shift-add step: add multiplicand into the high half when the multiplier LSB is set,
   // then shift the whole {carry, hi, lo} right by one.
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_d;
   logic [WIDTH-1:0] mul_lo_d;

   assign mul_sum  = {1'b0, acc_hi_q} + ({1'b0, opnd_q} & {(WIDTH+1){acc_lo_q[0]}});
   assign mul_hi_d = mul_sum[WIDTH:1];
   assign mul_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

   // One restoring-divide step on the (WIDTH+1)-bit value {rem, next dividend bit}.
   // A set remainder MSB means the shifted value already exceeds any WIDTH-bit divisor,
   // and the WIDTH-bit wrapped difference is then still exact. B=0 naturally yields
   // an all-ones quotient and a remainder equal to A.
   logic [WIDTH-1:0] div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] div_hi_d;
   logic [WIDTH-1:0] div_lo_d;

   assign div_shift = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
   assign div_diff  = div_shift - opnd_q;
   assign div_ge    = acc_hi_q[WIDTH-1] | (div_shift >= opnd_q);
   assign div_hi_d  = div_ge ? div_diff : div_shift;
   assign div_lo_d  = {acc_lo_q[WIDTH-2:0], div_ge};

   logic [WIDTH-1:0] iter_hi_d;
   logic [WIDTH-1:0] iter_lo_d;
   logic             iter_last;

   assign iter_hi_d = (state_q == S_MUL) ? mul_hi_d : div_hi_d;
   assign iter_lo_d = (state_q == S_MUL) ? mul_lo_d : div_lo_d;
   assign iter_last = (cnt_q == CW'(WIDTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         acc_hi_q    <= '0;
         acc_lo_q    <= '0;
         opnd_q      <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.Start) begin
                  if (op == OP_MULU || op == OP_DIVU) begin
                     opnd_q   <= (op == OP_MULU) ? bus.A : bus.B;
                     acc_lo_q <= (op == OP_MULU) ? bus.B : bus.A;
                     acc_hi_q <= '0;
                     cnt_q    <= '0;
                     busy_q   <= 1'b1;
                     state_q  <= (op == OP_MULU) ? S_MUL : S_DIV;
                  end else begin
                     result_q    <= simple_res;
                     result_hi_q <= '0;
                     zero_q      <= (simple_res == '0);
                     ovf_q       <= simple_ovf;
                     done_q      <= 1'b1;
                  end
               end
            end
            S_MUL, S_DIV: begin
               acc_hi_q <= iter_hi_d;
               acc_lo_q <= iter_lo_d;
               cnt_q    <= cnt_q + 1'b1;
               if (iter_last) begin
                  result_q    <= iter_lo_d;
                  result_hi_q <= iter_hi_d;
                  zero_q      <= (iter_lo_d == '0);
                  ovf_q       <= 1'b0;
                  done_q      <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.Result    = result_q;
   assign bus.Result_Hi = result_hi_q;
   assign bus.Zero_Flag = zero_q;
   assign bus.Overflow  = ovf_q;
   assign bus.Busy      = busy_q;
   assign bus.Done      = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: a WIDTH=32 instance for the main sequence and a
// WIDTH=8 instance for the short multiply.
module tb_alu_multicycle;

   logic clk;
   logic reset;

   alu_multicycle_if #(.WIDTH(32)) b32 ();
   alu_multicycle_if #(.WIDTH(8))  b8  ();

   alu_multicycle #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(reset), .bus(b32));
   alu_multicycle #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(b8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for Done on the 32-bit unit, counting Busy cycles; optionally
   // pulses an AND request at loop index inject_at while the unit is busy.
   task automatic wait32(input int inject_at, output int bc, output bit got);
      bc  = 0;
      got = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (b32.Done) begin
            got = 1'b1;
            break;
         end
         if (b32.Busy) bc++;
         if (i == inject_at) begin
            b32.Start      = 1'b1;
            b32.ALUControl = 3'd0;
            b32.A          = 32'h0;
            b32.B          = 32'h0;
         end else begin
            b32.Start = 1'b0;
         end
         tick();
      end
      b32.Start = 1'b0;
   endtask

   task automatic wait8(output int bc, output bit got);
      bc  = 0;
      got = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (b8.Done) begin
            got = 1'b1;
            break;
         end
         if (b8.Busy) bc++;
         tick();
      end
   endtask

   task automatic simple32(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
      b32.Start      = 1'b1;
      b32.ALUControl = ctl;
      b32.A          = a;
      b32.B          = b;
      tick();
      b32.Start = 1'b0;
   endtask

   int bc;
   bit got;
   int dones;

   initial begin
      reset          = 1'b1;
      b32.Start      = 1'b0;
      b32.ALUControl = 3'd0;
      b32.A          = '0;
      b32.B          = '0;
      b8.Start       = 1'b0;
      b8.ALUControl  = 3'd0;
      b8.A           = '0;
      b8.B           = '0;
      #12;
      check("rst_result",  b32.Result, 0);
      check("rst_hi",      b32.Result_Hi, 0);
      check("rst_zero",    b32.Zero_Flag, 0);
      check("rst_ovf",     b32.Overflow, 0);
      check("rst_busy",    b32.Busy, 0);
      check("rst_done",    b32.Done, 0);
      reset = 1'b0;
      tick();

      // ADD
      simple32(3'd2, 32'h0005_9460, 32'h0005_9461);
      check("add_result", b32.Result, 32'h000B_28C1);
      check("add_zero",   b32.Zero_Flag, 0);
      check("add_ovf",    b32.Overflow, 0);
      check("add_done",   b32.Done, 1);
      check("add_busy",   b32.Busy, 0);
      check("add_hi",     b32.Result_Hi, 0);
      tick();
      check("add_done_pulse", b32.Done, 0);
      check("add_hold",       b32.Result, 32'h000B_28C1);

      // SUB equal operands
      simple32(3'd6, 32'h0005_9460, 32'h0005_9460);
      check("sub_eq_result", b32.Result, 0);
      check("sub_eq_zero",   b32.Zero_Flag, 1);
      check("sub_eq_ovf",    b32.Overflow, 0);

      // SUB overflow, back-to-back with the previous op
      simple32(3'd6, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      check("sub_ovf_result", b32.Result, 32'h8000_0000);
      check("sub_ovf_flag",   b32.Overflow, 1);
      check("sub_ovf_zero",   b32.Zero_Flag, 0);
      check("sub_ovf_done",   b32.Done, 1);

      // ADD overflow: two large positives
      simple32(3'd2, 32'h7FFF_FFFF, 32'h0000_0001);
      check("add_ovf_result", b32.Result, 32'h8000_0000);
      check("add_ovf_flag",   b32.Overflow, 1);

      // XOR and AND
      simple32(3'd5, 32'h0000_F0F0, 32'h0000_FF00);
      check("xor_result", b32.Result, 32'h0000_0FF0);
      check("xor_ovf",    b32.Overflow, 0);
      simple32(3'd0, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
      check("and_result", b32.Result, 0);
      check("and_zero",   b32.Zero_Flag, 1);

      // SLT signed: -1 < 1
      simple32(3'd7, 32'hFFFF_FFFF, 32'h0000_0001);
      check("slt_result", b32.Result, 1);
      simple32(3'd7, 32'h0000_0001, 32'hFFFF_FFFF);
      check("slt_false",  b32.Result, 0);
      simple32(3'd7, 32'hFFFF_FFFF, 32'h0000_0001);
      tick();

      // MULU with an AND request injected mid-operation
      simple32(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("mul_busy_start", b32.Busy, 1);
      check("mul_hold_result", b32.Result, 1);
      wait32(3, bc, got);
      check("mul_done_seen", got, 1);
      check("mul_busy_cycles", bc, 32);
      check("mul_result", b32.Result, 32'h0000_0001);
      check("mul_hi",     b32.Result_Hi, 32'hFFFF_FFFE);
      check("mul_zero",   b32.Zero_Flag, 0);
      check("mul_busy_at_done", b32.Busy, 0);
      tick();
      check("mul_done_pulse", b32.Done, 0);

      // DIVU 100/7 followed by an OR request in the Done cycle
      simple32(3'd4, 32'd100, 32'd7);
      wait32(-1, bc, got);
      check("div_done_seen",   got, 1);
      check("div_busy_cycles", bc, 32);
      check("div_quot",        b32.Result, 32'd14);
      check("div_rem",         b32.Result_Hi, 32'd2);
      simple32(3'd1, 32'h0000_00F0, 32'h0000_000F);
      check("b2b_or_result", b32.Result, 32'h0000_00FF);
      check("b2b_or_done",   b32.Done, 1);
      check("b2b_or_hi",     b32.Result_Hi, 0);
      tick();

      // DIVU by zero
      simple32(3'd4, 32'h0000_1234, 32'h0);
      wait32(-1, bc, got);
      check("div0_done_seen",   got, 1);
      check("div0_busy_cycles", bc, 32);
      check("div0_quot",        b32.Result, 32'hFFFF_FFFF);
      check("div0_rem",         b32.Result_Hi, 32'h0000_1234);
      check("div0_ovf",         b32.Overflow, 0);
      tick();

      // Reset abort 10 cycles into a MULU
      simple32(3'd3, 32'h0000_1000, 32'h0000_1000);
      repeat (9) tick();
      check("abort_busy_before", b32.Busy, 1);
      check("abort_result_before", b32.Result_Hi, 32'h0000_1234);
      #2 reset = 1'b1;
      #1;
      check("abort_result", b32.Result, 0);
      check("abort_hi",     b32.Result_Hi, 0);
      check("abort_busy",   b32.Busy, 0);
      tick();
      tick();
      reset = 1'b0;
      dones = 0;
      repeat (40) begin
         tick();
         if (b32.Done) dones++;
      end
      check("abort_no_done", dones, 0);
      check("abort_stay_zero", b32.Result, 0);
      simple32(3'd2, 32'd3, 32'd4);
      check("post_reset_add", b32.Result, 32'd7);
      check("post_reset_done", b32.Done, 1);
      tick();

      // WIDTH=8 MULU
      b8.Start      = 1'b1;
      b8.ALUControl = 3'd3;
      b8.A          = 8'hFF;
      b8.B          = 8'hFF;
      tick();
      b8.Start = 1'b0;
      wait8(bc, got);
      check("mul8_done_seen",   got, 1);
      check("mul8_busy_cycles", bc, 8);
      check("mul8_result",      b8.Result, 8'h01);
      check("mul8_hi",          b8.Result_Hi, 8'hFE);
      tick();
      check("mul8_done_pulse",  b8.Done, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, clocked successor to the team's single-cycle combinational ALU, used by the multi-cycle datapath. It keeps the existing `ALUControl` operations (AND, OR, ADD, SUB, SLT) and the `Zero_Flag`, and adds XOR, unsigned multiply and unsigned divide. It also adds a signed-overflow flag and a Start/Busy/Done handshake. Simple operations complete in one clock; multiply and divide run iteratively for `WIDTH` clocks.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 4.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `Start` in 1: request; sampled on a rising edge only while `Busy` = 0.
- `ALUControl` in 3: operation select.
  - 0 AND, 1 OR, 2 ADD, 3 MULU, 4 DIVU, 5 XOR, 6 SUB, 7 SLT.
- `A` in WIDTH: operand A; latched when `Start` is accepted.
- `B` in WIDTH: operand B; latched when `Start` is accepted.
- `Result` out WIDTH: result low word, or quotient for DIVU.
- `Result_Hi` out WIDTH: high word of the MULU product, or remainder for DIVU; 0 for all other operations.
- `Zero_Flag` out 1: registered; 1 when the new `Result` is 0 (high word ignored).
- `Overflow` out 1: signed overflow for ADD/SUB; 0 for all other operations.
- `Busy` out 1: high while MULU/DIVU is iterating.
- `Done` out 1: one-cycle pulse marking that new outputs are valid.

## Operation
- States:
  - IDLE: accepts `Start`.
  - MUL: WIDTH-step shift-add.
  - DIV: WIDTH-step restoring shift-subtract.
- IDLE with `Start`=1 and a simple op:
  - On that edge, register `Result`, `Result_Hi`=0, `Zero_Flag`, `Overflow`; set `Done`=1.
  - Remain in IDLE.
- IDLE with `Start`=1 and MULU/DIVU:
  - Latch A, B and the op; clear the accumulator; iteration counter = 0.
  - Go to MUL or DIV; `Busy`=1.
- MUL/DIV:
  - One iteration per edge; counter increments each edge.
  - The edge performing iteration WIDTH writes `Result`, `Result_Hi`, `Zero_Flag`, `Overflow`=0, sets `Done`=1, returns to IDLE, and clears `Busy`.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - `Overflow` = operand signs agree (ADD) or differ (SUB), and the result sign differs from A.
  - SLT is a signed compare: `Result` = {0…0, A<B}.
  - MULU gives the full 2·WIDTH-bit unsigned product as {`Result_Hi`, `Result`}.
- DIVU with B=0:
  - Quotient = all ones, remainder = A.
  - Same WIDTH-cycle latency; no separate flag.
- `Start` while `Busy`=1 is ignored; the operands on the bus are not latched.
- `Start` in the same cycle that `Done`=1 is legal and is accepted; back-to-back simple ops give a `Done` pulse every cycle.
- Outputs other than `Done` hold their values until the next completion.
- Combinational inputs never drive outputs directly; all outputs are registered.

## Timing
- Reset values: `Result`=0, `Result_Hi`=0, `Zero_Flag`=0, `Overflow`=0, `Busy`=0, `Done`=0; state IDLE.
- Reset takes effect immediately (asynchronously).
- Reset during MUL/DIV aborts the operation: no `Done` follows, and the partial result is discarded.
- The first `Start` after reset is released behaves normally.
- Simple-op latency: `Start` sampled on edge N → `Done`=1 and outputs valid after edge N+1's predecessor; precisely, outputs update on edge N itself and are visible during cycle N..N+1. `Done` is high for exactly that one cycle.
- MULU/DIVU latency:
  - `Start` sampled on edge N → `Busy`=1 for cycles N..N+WIDTH−1.
  - Outputs update on edge N+WIDTH, with `Done`=1 for cycle N+WIDTH..N+WIDTH+1.
- `Done` and `Busy` are never high in the same cycle.

## Test plan
- **ADD:** WIDTH=32, ADD, A=0x00059460, B=0x00059461 → one cycle later `Result`=0x000B28C1, `Zero_Flag`=0, `Overflow`=0, a single `Done` pulse, `Busy` never high.
- **SUB and SLT:**
  - SUB A=B=0x00059460 → `Result`=0, `Zero_Flag`=1.
  - SUB A=0x7FFFFFFF, B=0xFFFFFFFF → `Result`=0x80000000, `Overflow`=1.
  - SLT A=0xFFFFFFFF, B=1 → `Result`=1.
- **MULU:** A=B=0xFFFFFFFF → `Busy` high for exactly 32 cycles; then `Result`=0x00000001, `Result_Hi`=0xFFFFFFFE, one `Done` pulse. An AND `Start` pulsed mid-operation is ignored (outputs unaffected).
- **DIVU:**
  - A=100, B=7 → `Result`=14, `Result_Hi`=2 after 32 cycles.
  - A=0x1234, B=0 → `Result`=0xFFFFFFFF, `Result_Hi`=0x1234.
- **Reset abort:** assert `reset` 10 cycles into a MULU → all outputs 0 immediately and no `Done` afterwards. A following ADD 3+4 → `Result`=7 with one-cycle latency.
- **Back-to-back:** a second `Start` (OR, 0xF0|0x0F) asserted in the `Done` cycle of a DIVU → accepted; `Result`=0xFF on the next cycle. Repeat with WIDTH=8 MULU 0xFF·0xFF → `Result_Hi`=0xFE, `Result`=0x01 after 8 cycles.
